// File: rtl/netbus_packer_pkg.sv
// Shared NetBus definitions: field layout of a NetBus word and the packer FSM
// state type. Reused by the packer, multiplexer and router blocks.
package netbus_packer_pkg;

    localparam int LANE_W  = 9;   // {tag, byte[7:0]}
    localparam int COUNT_W = 4;   // wide enough for COUNT = 15 without wrapping
    localparam int ROUTE_W = 8;

    // Packet FSM: IDLE means no packet is open, BODY means one is open.
    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } pkt_state_t;

    // Width of a NetBus word holding dw lanes plus route/SOP/EOP/COUNT.
    function automatic int netbus_word_w(input int dw);
        return dw * LANE_W + 14;
    endfunction

    // Field offsets inside a NetBus word; all fields sit above the lanes.
    function automatic int route_lsb(input int dw);
        return dw * LANE_W + 6;
    endfunction

    function automatic int sop_bit(input int dw);
        return dw * LANE_W + 5;
    endfunction

    function automatic int eop_bit(input int dw);
        return dw * LANE_W + 4;
    endfunction

    function automatic int count_lsb(input int dw);
        return dw * LANE_W;
    endfunction

endpackage

// File: rtl/netbus_packer_if.sv
// Byte-in / word-out handshake bundle of the NetBus packer.
// slave is the packer's view, master is the view of the logic around it.
interface netbus_packer_if #(
    parameter int DATA_WIDTH = 4
);
    import netbus_packer_pkg::*;

    logic [LANE_W-1:0]                    in_data;
    logic [ROUTE_W-1:0]                   in_route;
    logic                                 in_last;
    logic                                 in_valid;
    logic                                 in_ready;
    logic [netbus_word_w(DATA_WIDTH)-1:0] wdata;
    logic                                 wvalid;
    logic                                 wready;

    modport master (
        output in_data, in_route, in_last, in_valid, wready,
        input  in_ready, wdata, wvalid
    );

    modport slave (
        input  in_data, in_route, in_last, in_valid, wready,
        output in_ready, wdata, wvalid
    );

endinterface

// File: rtl/netbus_packer.sv
// NetBus packer: gathers bytes into DATA_WIDTH-lane NetBus words, tagging each
// word with the packet route, SOP/EOP and the number of valid lanes.
// One accumulator feeds one output register, so up to two words can be held
// while the NetBus side is stalled.
module netbus_packer
    import netbus_packer_pkg::*;
#(
    parameter int DATA_WIDTH = 4   // lanes per word, 1..15
) (
    input  logic           clk,
    input  logic           reset,
    netbus_packer_if.slave bus
);

    localparam int WORD_W    = netbus_word_w(DATA_WIDTH);
    localparam int ROUTE_LSB = route_lsb(DATA_WIDTH);
    localparam int SOP_BIT   = sop_bit(DATA_WIDTH);
    localparam int EOP_BIT   = eop_bit(DATA_WIDTH);
    localparam int COUNT_LSB = count_lsb(DATA_WIDTH);
    localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(DATA_WIDTH);

    typedef logic [DATA_WIDTH-1:0][LANE_W-1:0] lanes_t;

    pkt_state_t         state_q, state_d;
    lanes_t             acc_lanes_q, acc_lanes_d;
    logic [COUNT_W-1:0] acc_count_q, acc_count_d;
    logic               acc_done_q, acc_done_d;
    logic               acc_sop_q, acc_sop_d;
    logic               acc_eop_q, acc_eop_d;
    logic [ROUTE_W-1:0] route_q;
    logic               ready_en_q;
    logic [WORD_W-1:0]  word_d;
    logic [WORD_W-1:0]  wdata_q;
    logic               wvalid_q;

    logic out_free;   // output register can take a word at the next edge
    logic load;       // completed accumulator moves to the output register
    logic accept;     // byte transfer on the input side

    assign out_free = !wvalid_q || bus.wready;
    assign load     = acc_done_q && out_free;
    // Stall only when a finished word has nowhere to go; in_valid is not used.
    assign bus.in_ready = ready_en_q && !(acc_done_q && !out_free);
    assign accept       = bus.in_valid && bus.in_ready;

    assign bus.wdata  = wdata_q;
    assign bus.wvalid = wvalid_q;

    // Packet FSM next state: a last byte always closes the packet.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        if (accept) begin
            state_d = bus.in_last ? IDLE : BODY;
        end
    end

    // Packet FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Accumulator next state: empty it on load, then append any accepted byte.
    always_comb begin
        acc_lanes_d = acc_lanes_q;
        acc_count_d = acc_count_q;
        acc_done_d  = acc_done_q;
        acc_sop_d   = acc_sop_q;
        acc_eop_d   = acc_eop_q;

        if (load) begin
            acc_count_d = '0;
            acc_done_d  = 1'b0;
        end

        if (accept) begin
            // First byte of a word: clear all lanes so unused lanes read zero.
            if (acc_count_d == '0) begin
                acc_lanes_d = '0;
                acc_sop_d   = (state_q == IDLE);
            end
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if (acc_count_d == COUNT_W'(i)) begin
                    acc_lanes_d[i] = bus.in_data;
                end
            end
            acc_count_d = acc_count_d + COUNT_W'(1);
            acc_done_d  = bus.in_last || (acc_count_d == FULL_COUNT);
            acc_eop_d   = bus.in_last;
        end
    end

    // Accumulator control, packet route latch and post-reset ready enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_count_q <= '0;
            acc_done_q  <= 1'b0;
            acc_sop_q   <= 1'b0;
            acc_eop_q   <= 1'b0;
            route_q     <= '0;
            ready_en_q  <= 1'b0;
        end else begin
            acc_count_q <= acc_count_d;
            acc_done_q  <= acc_done_d;
            acc_sop_q   <= acc_sop_d;
            acc_eop_q   <= acc_eop_d;
            ready_en_q  <= 1'b1;
            // Route is taken from the first byte only; later changes are ignored.
            if (accept && state_q == IDLE) begin
                route_q <= bus.in_route;
            end
        end
    end

    // Accumulator lane storage.
    always_ff @(posedge clk) begin
        // NOTE: lane data is not reset; lanes are cleared when a word's first byte arrives and are only read with a valid count.
        acc_lanes_q <= acc_lanes_d;
    end

    // Assemble the outgoing NetBus word from the completed accumulator.
    always_comb begin
        word_d                              = '0;
        word_d[ROUTE_LSB +: ROUTE_W]        = route_q;
        word_d[SOP_BIT]                     = acc_sop_q;
        word_d[EOP_BIT]                     = acc_eop_q;
        word_d[COUNT_LSB +: COUNT_W]        = acc_count_q;
        word_d[DATA_WIDTH*LANE_W-1:0]       = acc_lanes_q;
    end

    // Output register: load a finished word, otherwise hold until taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            wvalid_q <= 1'b0;
            wdata_q  <= '0;
        end else if (load) begin
            wvalid_q <= 1'b1;
            wdata_q  <= word_d;
        end else if (bus.wready) begin
            wvalid_q <= 1'b0;
        end
    end

endmodule
